// File: rtl/trigger_debounce.sv
// Push-button conditioner: two-flop synchroniser, counter-qualified debounce FSM,
// press/release strobes and a wrapping press counter. Define TRIGGER_REPEAT_EN for auto-repeat.
module trigger_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 256,
    parameter int REPEAT_PERIOD   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       trigger,
    output logic       trigger_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("trigger_debounce: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s2_q;
    logic             trigger_q, trigger_d;
    logic             tpulse_q, tpulse_d;
    logic             rpulse_q, rpulse_d;
    logic [7:0]       count_q, count_d;

`ifdef TRIGGER_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    // phase 0 waits out the initial delay, phase 1 runs the repeat period
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             phase_q, phase_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            trigger_q <= 1'b0;
            tpulse_q  <= 1'b0;
            rpulse_q  <= 1'b0;
            count_q   <= 8'd0;
`ifdef TRIGGER_REPEAT_EN
            rpt_q     <= '0;
            phase_q   <= 1'b0;
`endif
        end else begin
            s1_q      <= btn_in;
            s2_q      <= s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            trigger_q <= trigger_d;
            tpulse_q  <= tpulse_d;
            rpulse_q  <= rpulse_d;
            count_q   <= count_d;
`ifdef TRIGGER_REPEAT_EN
            rpt_q     <= rpt_d;
            phase_q   <= phase_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tpulse_d = 1'b0;
        rpulse_d = 1'b0;
        count_d  = count_q;
`ifdef TRIGGER_REPEAT_EN
        rpt_d    = rpt_q;
        phase_d  = phase_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = PRESSED;
                    cnt_d    = '0;
                    tpulse_d = 1'b1;
                    count_d  = count_q + 8'd1;
`ifdef TRIGGER_REPEAT_EN
                    rpt_d    = '0;
                    phase_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
`ifdef TRIGGER_REPEAT_EN
                    rpt_d = rpt_q + RPT_W'(1);
                    if ((!phase_q && rpt_q == RPT_DELAY_LAST) ||
                        ( phase_q && rpt_q == RPT_PERIOD_LAST)) begin
                        tpulse_d = 1'b1;
                        rpt_d    = '0;
                        phase_d  = 1'b1;
                    end
`endif
                end
            end
            RELEASE_WAIT: begin
                // the repeat timer holds here; it restarts on re-entry to PRESSED
                if (s2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
`ifdef TRIGGER_REPEAT_EN
                    rpt_d   = '0;
                    phase_d = 1'b0;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    rpulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        trigger_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    assign trigger       = trigger_q;
    assign trigger_pulse = tpulse_q;
    assign release_pulse = rpulse_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_trigger_debounce.sv
// Bench for trigger_debounce: directed scenarios plus randomized button activity,
// every cycle checked against a run-length reference model of the debounce rules.
module tb_trigger_debounce;

    localparam int DC = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn = 1'b0;
    logic       trigger, trigger_pulse, release_pulse;
    logic [7:0] press_count;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit m_s1, m_s2, m_level;
    int m_run, m_count, m_elapsed;
    bit exp_tp, exp_rp;

    trigger_debounce #(
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn),
        .trigger      (trigger),
        .trigger_pulse(trigger_pulse),
        .release_pulse(release_pulse),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One rising edge of the spec's behaviour: a level flips once DC consecutive
    // synchronised samples disagree with it; any agreeing sample restarts the run.
    task automatic model_edge(input bit b, input bit r);
        bit samp;
        exp_tp = 1'b0;
        exp_rp = 1'b0;
        if (!r) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_count = 0; m_elapsed = 0;
        end else begin
            samp = m_s2;
            m_s2 = m_s1;
            m_s1 = b;
            if (samp != m_level) begin
                m_run++;
                if (m_run == DC) begin
                    m_level = samp;
                    m_run   = 0;
                    if (samp) begin
                        exp_tp    = 1'b1;
                        m_count   = (m_count + 1) % 256;
                        m_elapsed = 0;
                    end else begin
                        exp_rp = 1'b1;
                    end
                end
            end else begin
                if (m_level && m_run == 0) begin
                    m_elapsed++;
`ifdef TRIGGER_REPEAT_EN
                    if (m_elapsed == RD || (m_elapsed > RD && (m_elapsed - RD) % RP == 0))
                        exp_tp = 1'b1;
`endif
                end else begin
                    m_elapsed = 0;
                end
                m_run = 0;
            end
        end
    endtask

    task automatic step(input bit b, input bit r);
        btn = b;
        rst = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        check_val("trigger", int'(trigger), int'(m_level));
        check_val("trigger_pulse", int'(trigger_pulse), int'(exp_tp));
        check_val("release_pulse", int'(release_pulse), int'(exp_rp));
        check_val("press_count", int'(press_count), m_count);
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b1);
    endtask

    initial begin
        int base;
        bit bounce [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // reset state
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_val("rst_trigger", int'(trigger), 0);
        check_val("rst_count", int'(press_count), 0);
        hold(1'b0, 6);
        $display("scenario reset done");

        // 1: clean press, exact latency
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1);
            if (i == 5) check_val("s1_trig_early", int'(trigger), 0);
            if (i == 6) begin
                check_val("s1_trig_on", int'(trigger), 1);
                check_val("s1_pulse_on", int'(trigger_pulse), 1);
                check_val("s1_count", int'(press_count), 1);
            end
            if (i == 7) check_val("s1_pulse_off", int'(trigger_pulse), 0);
        end
        hold(1'b0, 10);
        $display("scenario clean press done");

        // 2: bounce then hold, exactly one press accepted
        base = m_count;
        foreach (bounce[i]) step(bounce[i], 1'b1);
        hold(1'b1, 12);
        check_val("s2_count", int'(press_count), (base + 1) % 256);
        $display("scenario bounce done");

        // 3: release glitch, then clean release
        hold(1'b0, 2);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1);
            check_val("s3_glitch_trig", int'(trigger), 1);
            check_val("s3_glitch_rel", int'(release_pulse), 0);
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1);
            if (i == 5) check_val("s3_rel_early", int'(release_pulse), 0);
            if (i == 6) check_val("s3_rel_on", int'(release_pulse), 1);
        end
        check_val("s3_count", int'(press_count), (base + 1) % 256);
        $display("scenario release glitch done");

        // 4: wrap after 257 presses, then reset mid-PRESS_WAIT with button held
        step(1'b0, 1'b0);
        for (int p = 0; p < 257; p++) begin
            hold(1'b1, 8);
            hold(1'b0, 8);
        end
        check_val("s4_wrap", int'(press_count), 1);
        hold(1'b1, 3);
        step(1'b1, 1'b0);
        check_val("s4_rst_trig", int'(trigger), 0);
        check_val("s4_rst_pulse", int'(trigger_pulse), 0);
        check_val("s4_rst_count", int'(press_count), 0);
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 1'b1);
            if (i == 5) check_val("s4_trig_early", int'(trigger), 0);
            if (i == 6) check_val("s4_trig_on", int'(trigger), 1);
        end
        check_val("s4_count", int'(press_count), 1);
        $display("scenario wrap and reset done");

        // 5: long hold (auto-repeat pulses only with the macro defined)
        hold(1'b0, 10);
        base = m_count;
        hold(1'b1, 36);
        check_val("s5_count", int'(press_count), (base + 1) % 256);
        hold(1'b0, 10);
        $display("scenario long hold done");

        // randomized segments with occasional reset
        for (int s = 0; s < 300; s++) begin
            int  len = $urandom_range(1, 12);
            bit  v   = bit'($urandom_range(0, 1));
            bit  r   = ($urandom_range(0, 40) != 0);
            step(v, r);
            for (int c = 1; c < len; c++) step(v, 1'b1);
        end
        $display("scenario random done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
